// File: rtl/packet_replay_engine_pkg.sv
// Shared helpers for the packet replay engine: sizing functions used by the top
// and its buffer.
package packet_replay_engine_pkg;

  function automatic int fun_sizeof_byte(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int fun_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/replay_buffer_ram.sv
// Byte-wide frame store: one synchronous write port, one asynchronous read port.
module replay_buffer_ram #(
  parameter int DEPTH = 56,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/packet_replay_engine.sv
// Frame buffer with cumulative acknowledge and on-demand replay of the
// outstanding frames as a byte stream.
module packet_replay_engine
  import packet_replay_engine_pkg::*;
#(
  parameter int FRAME_WIDTH = 56,
  parameter int ID_WIDTH    = 3
) (
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic                i_wr,
  input  logic [7:0]          i_wr_byte,
  output logic [ID_WIDTH-1:0] o_wr_id,
  input  logic                i_ack,
  input  logic [ID_WIDTH-1:0] i_ack_id,
  input  logic                i_replay,
  output logic                o_rd_valid,
  output logic [7:0]          o_rd_byte,
  output logic [ID_WIDTH-1:0] o_rd_id,
  output logic                o_rd_sof,
  output logic                o_rd_eof,
  input  logic                i_rd_ready,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_busy,
  output logic                o_err
);

  localparam int FRAME_BYTES = fun_sizeof_byte(FRAME_WIDTH);
  localparam int SLOTS       = 2 ** ID_WIDTH;
  localparam int DEPTH       = SLOTS * FRAME_BYTES;
  localparam int AW          = fun_clog2_min1(DEPTH);
  localparam int BW          = fun_clog2_min1(FRAME_BYTES);
  localparam int CW          = ID_WIDTH + 1;

  localparam logic [BW-1:0]       LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [BW-1:0]       BW_ONE    = BW'(1);
  localparam logic [ID_WIDTH-1:0] ID_ONE    = ID_WIDTH'(1);
  localparam logic [CW-1:0]       CW_ONE    = CW'(1);
  localparam logic [CW-1:0]       SLOTS_C   = CW'(SLOTS);

  typedef enum logic {IDLE, REPLAY} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] head, tail, tail_nxt;
  logic [ID_WIDTH-1:0] rd_id, rd_id_nxt, end_id, end_id_nxt, next_id, ack_dist, rd_dist;
  logic [CW-1:0]       count, count_nxt;
  logic [BW-1:0]       wr_idx, rd_idx, rd_idx_nxt;
  logic                wr_ok, commit, ack_ok, err_nxt, xfer;
  logic [AW-1:0]       wr_addr, rd_addr;

  assign wr_ok    = i_wr && !o_full;
  assign commit   = wr_ok && (wr_idx == LAST_BYTE);
  assign ack_dist = i_ack_id - tail;
  assign ack_ok   = i_ack && ({1'b0, ack_dist} < count);
  assign err_nxt  = (i_wr && o_full) || (i_ack && !ack_ok);

  always_comb begin
    tail_nxt  = tail;
    count_nxt = count + CW'(commit);
    if (ack_ok) begin
      tail_nxt  = i_ack_id + ID_ONE;
      count_nxt = count_nxt - ({1'b0, ack_dist} + CW_ONE);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_idx <= '0;
      o_err  <= 1'b0;
    end else begin
      if (wr_ok) wr_idx <= commit ? '0 : wr_idx + BW_ONE;
      if (commit) head <= head + ID_ONE;
      tail  <= tail_nxt;
      count <= count_nxt;
      o_err <= err_nxt;
    end
  end

  // Next frame after eof: the successor while the current frame is still
  // outstanding (post-ack view), otherwise jump to the oldest outstanding frame.
  assign xfer    = (state == REPLAY) && i_rd_ready;
  assign rd_dist = rd_id - tail_nxt;
  assign next_id = ({1'b0, rd_dist} < count_nxt) ? rd_id + ID_ONE : tail_nxt;

  always_comb begin
    state_nxt  = state;
    rd_id_nxt  = rd_id;
    rd_idx_nxt = rd_idx;
    end_id_nxt = end_id;
    case (state)
      IDLE: begin
        if (i_replay && count != '0) begin
          state_nxt  = REPLAY;
          end_id_nxt = head;
          rd_id_nxt  = tail;
          rd_idx_nxt = '0;
        end
      end
      REPLAY: begin
        if (xfer) begin
          if (rd_idx != LAST_BYTE) begin
            rd_idx_nxt = rd_idx + BW_ONE;
          end else begin
            rd_idx_nxt = '0;
            rd_id_nxt  = next_id;
            if (next_id == end_id || count_nxt == '0) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= IDLE;
      rd_id  <= '0;
      rd_idx <= '0;
      end_id <= '0;
    end else begin
      state  <= state_nxt;
      rd_id  <= rd_id_nxt;
      rd_idx <= rd_idx_nxt;
      end_id <= end_id_nxt;
    end
  end

  assign wr_addr = AW'(head) * AW'(FRAME_BYTES) + AW'(wr_idx);
  assign rd_addr = AW'(rd_id) * AW'(FRAME_BYTES) + AW'(rd_idx);

  replay_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (i_wr_byte),
    .rd_addr (rd_addr),
    .rd_data (o_rd_byte)
  );

  assign o_wr_id    = head;
  assign o_full     = (count == SLOTS_C);
  assign o_empty    = (count == '0);
  assign o_busy     = (state == REPLAY);
  assign o_rd_valid = o_busy;
  assign o_rd_id    = rd_id;
  assign o_rd_sof   = o_busy && (rd_idx == '0);
  assign o_rd_eof   = o_busy && (rd_idx == LAST_BYTE);

endmodule

// File: tb/tb_packet_replay_engine.sv
// Randomized bench for packet_replay_engine against a queue-based model of the
// outstanding frames and their stored bytes.
module tb_packet_replay_engine;

  localparam int IW    = 3;
  localparam int FB    = 7;
  localparam int SLOTS = 8;

  logic          i_clk = 1'b0;
  logic          i_arst, i_wr, i_ack, i_replay, i_rd_ready;
  logic [7:0]    i_wr_byte;
  logic [IW-1:0] i_ack_id;
  logic [IW-1:0] o_wr_id, o_rd_id;
  logic [7:0]    o_rd_byte;
  logic          o_rd_valid, o_rd_sof, o_rd_eof, o_full, o_empty, o_busy, o_err;

  int checks   = 0;
  int failures = 0;

  byte unsigned mem_m [SLOTS][FB];
  int q[$];
  int exp_q[$];
  int head_m = 0;
  int widx_m = 0;

  always #5 i_clk = ~i_clk;

  packet_replay_engine #(
    .FRAME_WIDTH (56),
    .ID_WIDTH    (IW)
  ) dut (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_wr       (i_wr),
    .i_wr_byte  (i_wr_byte),
    .o_wr_id    (o_wr_id),
    .i_ack      (i_ack),
    .i_ack_id   (i_ack_id),
    .i_replay   (i_replay),
    .o_rd_valid (o_rd_valid),
    .o_rd_byte  (o_rd_byte),
    .o_rd_id    (o_rd_id),
    .o_rd_sof   (o_rd_sof),
    .o_rd_eof   (o_rd_eof),
    .i_rd_ready (i_rd_ready),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".wr_id"}, 32'(o_wr_id), 32'(head_m));
    check_eq({tag, ".empty"}, 32'(o_empty), 32'(q.size() == 0));
    check_eq({tag, ".full"}, 32'(o_full), 32'(q.size() == SLOTS));
  endtask

  task automatic write_byte(input int b);
    bit drop;
    drop = (q.size() == SLOTS);
    i_wr = 1'b1;
    i_wr_byte = 8'(b);
    step();
    i_wr = 1'b0;
    if (!drop) begin
      mem_m[head_m][widx_m] = 8'(b);
      widx_m++;
      if (widx_m == FB) begin
        widx_m = 0;
        q.push_back(head_m);
        head_m = (head_m + 1) % SLOTS;
      end
    end
    check_eq("wr.err", 32'(o_err), 32'(drop));
    check_status("wr");
  endtask

  task automatic write_frame();
    for (int i = 0; i < FB; i++) write_byte(int'($urandom_range(0, 255)));
  endtask

  task automatic model_ack(input int id, output int pos);
    pos = -1;
    for (int k = 0; k < q.size(); k++)
      if (q[k] == id && pos < 0) pos = k;
    if (pos >= 0) repeat (pos + 1) void'(q.pop_front());
  endtask

  task automatic do_ack(input int id);
    int pos;
    i_ack = 1'b1;
    i_ack_id = IW'(id);
    step();
    i_ack = 1'b0;
    model_ack(id, pos);
    check_eq("ack.err", 32'(o_err), 32'(pos < 0));
    check_status("ack");
  endtask

  // Replays exp_q with random ready stalls; optionally acks ack_id after ack_at bytes.
  task automatic replay_run(input string tag, input int ack_at, input int ack_id, input int stall_pct);
    int n, fi, bi, cyc, id, pos;
    bit held, acked, poked, ack_now;
    logic [7:0] pb;
    logic [IW-1:0] pid;
    logic ps, pe;
    n = 0; fi = 0; bi = 0; cyc = 0;
    held = 0; acked = 0; poked = 0;
    pb = '0; pid = '0; ps = 1'b0; pe = 1'b0;
    i_replay = 1'b1;
    step();
    i_replay = 1'b0;
    check_eq({tag, ".busy"}, 32'(o_busy), 1);
    while (o_busy && cyc < 3000) begin
      cyc++;
      i_rd_ready = ($urandom_range(0, 99) >= stall_pct);
      if (held) begin
        check_eq({tag, ".hold_byte"}, 32'(o_rd_byte), 32'(pb));
        check_eq({tag, ".hold_id"}, 32'(o_rd_id), 32'(pid));
        check_eq({tag, ".hold_sof"}, 32'(o_rd_sof), 32'(ps));
        check_eq({tag, ".hold_eof"}, 32'(o_rd_eof), 32'(pe));
      end
      ack_now = (ack_at >= 0 && n == ack_at && !acked);
      if (ack_now) begin
        i_ack = 1'b1;
        i_ack_id = IW'(ack_id);
        acked = 1;
        model_ack(ack_id, pos);
      end
      if (n == 5 && !poked) begin
        i_replay = 1'b1;
        poked = 1;
      end
      if (o_rd_valid && i_rd_ready) begin
        if (fi < exp_q.size()) begin
          id = exp_q[fi];
          check_eq({tag, ".id"}, 32'(o_rd_id), 32'(id));
          check_eq({tag, ".data"}, 32'(o_rd_byte), 32'(mem_m[id][bi]));
          check_eq({tag, ".sof"}, 32'(o_rd_sof), 32'(bi == 0));
          check_eq({tag, ".eof"}, 32'(o_rd_eof), 32'(bi == FB - 1));
        end
        n++;
        bi++;
        if (bi == FB) begin
          bi = 0;
          fi++;
        end
      end
      held = o_rd_valid && !i_rd_ready;
      pb = o_rd_byte; pid = o_rd_id; ps = o_rd_sof; pe = o_rd_eof;
      step();
      i_ack = 1'b0;
      i_replay = 1'b0;
      if (ack_now) check_eq({tag, ".ack_err"}, 32'(o_err), 32'(pos < 0));
    end
    i_rd_ready = 1'b0;
    check_eq({tag, ".done"}, 32'(o_busy), 0);
    check_eq({tag, ".nbytes"}, 32'(n), 32'(exp_q.size() * FB));
  endtask

  initial begin
    i_arst = 1'b0; i_wr = 1'b0; i_wr_byte = '0; i_ack = 1'b0; i_ack_id = '0;
    i_replay = 1'b0; i_rd_ready = 1'b0;
    #1 i_arst = 1'b1;
    #2;
    check_eq("rst.full", 32'(o_full), 0);
    check_eq("rst.empty", 32'(o_empty), 1);
    check_eq("rst.busy", 32'(o_busy), 0);
    check_eq("rst.err", 32'(o_err), 0);
    check_eq("rst.rd_valid", 32'(o_rd_valid), 0);
    check_eq("rst.wr_id", 32'(o_wr_id), 0);
    #19 i_arst = 1'b0;
    step();
    check_status("idle");

    // First frame commits on the seventh byte.
    write_frame();
    check_eq("f1.wr_id", 32'(o_wr_id), 1);
    check_eq("f1.empty", 32'(o_empty), 0);

    // Fill all slots, then a dropped byte.
    repeat (7) write_frame();
    check_eq("fill.full", 32'(o_full), 1);
    write_byte(int'($urandom_range(0, 255)));
    step();
    check_eq("drop.err_clear", 32'(o_err), 0);
    exp_q = q;
    replay_run("full", -1, 0, 30);

    do_ack(7);
    i_replay = 1'b1;
    step();
    i_replay = 1'b0;
    check_eq("noreplay.busy", 32'(o_busy), 0);
    check_eq("noreplay.valid", 32'(o_rd_valid), 0);

    // Out-of-window ack with tail 0 and two outstanding.
    repeat (2) write_frame();
    do_ack(5);
    write_frame();
    check_eq("three.count", 32'(q.size()), 3);
    exp_q = q;
    replay_run("three", -1, 0, 50);

    // Ack of frame 1 while frame 0 is in flight.
    exp_q = {0, 2};
    replay_run("ackmid", 3, 1, 30);
    check_status("ackmid");

    // Wrap: 20 frames with acks crossing ID 7 -> 0.
    for (int f = 0; f < 20; f++) begin
      if (q.size() >= 5) do_ack(q[$urandom_range(1, q.size() - 1)]);
      if (f % 6 == 5) do_ack(head_m);
      write_frame();
      if (f % 7 == 6) begin
        exp_q = q;
        replay_run("wrap", -1, 0, 25);
      end
    end
    exp_q = q;
    replay_run("wrap_end", -1, 0, 40);

    // Reset in the middle of a replay.
    i_replay = 1'b1;
    step();
    i_replay = 1'b0;
    i_rd_ready = 1'b1;
    step();
    step();
    #3 i_arst = 1'b1;
    #1;
    check_eq("arst.rd_valid", 32'(o_rd_valid), 0);
    check_eq("arst.busy", 32'(o_busy), 0);
    check_eq("arst.full", 32'(o_full), 0);
    check_eq("arst.empty", 32'(o_empty), 1);
    check_eq("arst.err", 32'(o_err), 0);
    check_eq("arst.wr_id", 32'(o_wr_id), 0);
    q.delete();
    head_m = 0;
    widx_m = 0;
    #2 i_arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst.valid", 32'(o_rd_valid), 0);
    end
    i_rd_ready = 1'b0;
    write_frame();
    exp_q = q;
    replay_run("post_rst", -1, 0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_replay_engine.md
PACKET_REPLAY_ENGINE -- requirements
Module: packet_replay_engine

Interface
REQ-001 The block SHALL have parameter FRAME_WIDTH, default 56: payload bits per frame; FRAME_BYTES = ceil(FRAME_WIDTH/8).
REQ-002 The block SHALL have parameter ID_WIDTH, default 3: frame ID width; SLOTS = 2**ID_WIDTH.
REQ-003 The block SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-004 The block SHALL have port i_arst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_wr, input, 1: write strobe for one byte.
REQ-006 The block SHALL have port i_wr_byte, input, 8: write data.
REQ-007 The block SHALL have port o_wr_id, output, ID_WIDTH: ID of the frame being written.
REQ-008 The block SHALL have port i_ack / i_ack_id, input, 1 / ID_WIDTH: cumulative acknowledge.
REQ-009 The block SHALL have port i_replay, input, 1: replay request pulse.
REQ-010 The block SHALL have port o_rd_valid / o_rd_byte / o_rd_id / o_rd_sof / o_rd_eof, output, 1/8/ID_WIDTH/1/1: replay stream.
REQ-011 The block SHALL have port i_rd_ready, input, 1: replay stream ready.
REQ-012 The block SHALL have port o_full / o_empty / o_busy / o_err, output, 1 each: status; o_err is a one-cycle pulse.

Function
REQ-013 The block SHALL store bytes at slot(o_wr_id)*FRAME_BYTES + byte index; byte index increments on each accepted i_wr.
REQ-014 The block SHALL commit a frame on the FRAME_BYTES-th accepted byte: byte index returns to 0, head (o_wr_id) increments mod SLOTS, outstanding count +1.
REQ-015 The block SHALL assert o_full when count == SLOTS; i_wr while o_full is dropped and pulses o_err.
REQ-016 The block SHALL assert o_empty when count == 0; a partially written frame is not counted.
REQ-017 The block SHALL accept i_ack only if (i_ack_id - tail) mod SLOTS < count; then tail = i_ack_id+1, count -= (i_ack_id - tail)+1.
REQ-018 The block SHALL ignore an out-of-window ack and pulse o_err.
REQ-019 The block SHALL apply a commit and an ack in the same cycle as count + 1 - released.
REQ-020 The block SHALL implement FSM IDLE -> REPLAY on i_replay with count > 0, snapshotting end = head and setting rd pointer to tail byte 0; with count == 0 it stays IDLE and does nothing.
REQ-021 The block SHALL ignore i_replay while in REPLAY; o_busy = (state == REPLAY).
REQ-022 The block SHALL hold o_rd_valid high in REPLAY; a byte transfers when o_rd_valid && i_rd_ready, and o_rd_byte/id/sof/eof stay stable until then.
REQ-023 The block SHALL read memory asynchronously from the registered rd pointer, giving zero-latency o_rd_byte.
REQ-024 The block SHALL assert o_rd_sof on byte 0 and o_rd_eof on byte FRAME_BYTES-1 of each frame.
REQ-025 The block SHALL always complete a frame in progress; at each frame boundary, the next ID is next+1 if still outstanding, else tail.
REQ-026 The block SHALL return to IDLE after the eof transfer when the next ID == end or count == 0.
REQ-027 The block SHALL continue to accept writes and commits during REPLAY; frames committed after the snapshot are not replayed.

Reset
REQ-028 The block SHALL, on i_arst, immediately clear head, tail, count, byte index and rd pointer to 0 and set state to IDLE.
REQ-029 The block SHALL reset o_full=0, o_empty=1, o_busy=0, o_err=0, o_rd_valid=0, o_wr_id=0; memory content is not reset.
REQ-030 The block SHALL abort a replay or a partial write in progress on reset, with no further stream output.

Structure
REQ-031 The block SHALL take FRAME_BYTES from fun_sizeof_byte in the shared global functions header; the FSM state encoding SHALL be a local constant.
REQ-032 The block SHALL instantiate one sub-module, replay_buffer_ram: 1W1R, 8-bit, SLOTS*FRAME_BYTES deep, synchronous write and asynchronous read.

Verification
REQ-033 The bench SHALL check: defaults, write 7 bytes -> o_wr_id 0->1, count 1, o_empty=0.
REQ-034 The bench SHALL check: commit 8 frames -> o_full=1; a 57th byte -> o_err pulse and memory unchanged.
REQ-035 The bench SHALL check: 3 frames outstanding, i_replay with i_rd_ready stalled randomly -> 21 bytes IDs 0,1,2 with sof/eof correct and data matching, then o_busy=0.
REQ-036 The bench SHALL check: i_ack_id=1 mid-replay of frame 0 -> frame 0 completes, frame 2 follows, frame 1 skipped.
REQ-037 The bench SHALL check: i_ack_id=5 with tail=0, count=2 -> o_err pulse, count stays 2; wrap test with 20 frames and acks crossing ID 7->0.
REQ-038 The bench SHALL check: i_arst asserted mid-replay -> o_rd_valid=0 and all status at reset values in the same cycle.
